imem_ctrl: RTL and testbench

Sequencing and arbitration controller for the 32-word single-port instruction memory. After reset it clears the memory, accepts a program image over a valid/ready load port, then serves CPU instruction fetches each cycle. A debug port shares the memory under CPU priority with a starvation bound. It sits between the PC/fetch stage and the memory array and replaces simulation-only program initialisation in synthesisable builds.

---
 rtl/imem_ctrl_pkg.sv | 16 +
 rtl/imem_arb.sv | 35 +++
 rtl/imem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_imem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory controller.
package imem_ctrl_pkg;

   localparam int DEPTH      = 32;
   localparam int AW         = 5;
   localparam int STARVE_MAX = 4;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/imem_arb.sv
// Fetch/debug arbiter: fetch has priority, but debug is forced through after
// STARVE_MAX consecutive denied cycles.
module imem_arb
   import imem_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_en,
   input  logic fetch_req,
   input  logic dbg_req,
   output logic fetch_gnt,
   output logic dbg_gnt
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_q;

   // grant decision for the current cycle
   always_comb begin
      fetch_gnt = run_en && fetch_req && (starve_q < SW'(STARVE_MAX));
      dbg_gnt   = run_en && dbg_req && !fetch_gnt;
   end

   // count consecutive cycles in which a debug request was turned away
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         starve_q <= '0;
      else if (!run_en || !dbg_req || dbg_gnt)
         starve_q <= '0;
      else
         starve_q <= starve_q + SW'(1);
   end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: clears the array, loads a program image,
// then serves CPU fetches with a debug port sharing the memory.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   CLEAR | write 0 to every word, one per cycle
//   LOAD  | accept program words over valid/ready until last word or full
//   RUN   | one access per cycle: CPU fetch or debug, via imem_arb
module imem_ctrl
   import imem_ctrl_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          fetch_req_i,
   input  logic [31:0]   pc_addr_i,
   output logic [31:0]   instr_o,
   output logic          instr_valid_o,
   output logic          stall_o,
   output logic          addr_err_o,
   output logic          boot_done_o,
   input  logic          load_valid_i,
   output logic          load_ready_o,
   input  logic [31:0]   load_data_i,
   input  logic          load_last_i,
   input  logic          dbg_req_i,
   input  logic          dbg_we_i,
   input  logic [AW-1:0] dbg_addr_i,
   input  logic [31:0]   dbg_wdata_i,
   output logic          dbg_gnt_o,
   output logic [31:0]   dbg_rdata_o,
   output logic          dbg_rvalid_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i
);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          fetch_pend_q, dbg_rd_pend_q, err_pend_q;
   logic [31:0]   instr_q, dbg_rdata_q;
   logic          pc_ok, at_end, load_acc;
   logic          fetch_req, dbg_req, err_req;
   logic          fetch_gnt, dbg_gnt;

   assign pc_ok    = (pc_addr_i[1:0] == 2'b00) && (pc_addr_i[31:AW+2] == '0);
   assign at_end   = (addr_q == AW'(DEPTH - 1));
   assign load_acc = (state_q == LOAD) && load_valid_i;

   // misaligned/out-of-range fetches never reach the arbiter or the memory
   assign fetch_req = (state_q == RUN) && fetch_req_i && pc_ok;
   assign err_req   = (state_q == RUN) && fetch_req_i && !pc_ok;
   assign dbg_req   = (state_q == RUN) && dbg_req_i;

   imem_arb u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .run_en    (state_q == RUN),
      .fetch_req (fetch_req),
      .dbg_req   (dbg_req),
      .fetch_gnt (fetch_gnt),
      .dbg_gnt   (dbg_gnt)
   );

   // state and address counter registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= CLEAR;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // next state; the counter wraps to 0 naturally when leaving CLEAR
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         CLEAR: begin
            addr_d = addr_q + AW'(1);
            if (at_end) state_d = LOAD;
         end
         LOAD: begin
            if (load_acc) begin
               addr_d = addr_q + AW'(1);
               if (load_last_i || at_end) state_d = RUN;
            end
         end
         RUN: ;
         default: state_d = CLEAR;
      endcase
   end

   // memory port, handshake and stall; everything held low while in reset
   always_comb begin
      mem_en_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      load_ready_o = 1'b0;
      stall_o      = 1'b0;
      dbg_gnt_o    = 1'b0;
      if (rst_i) begin
         case (state_q)
            CLEAR: begin
               mem_en_o   = 1'b1;
               mem_we_o   = 1'b1;
               mem_addr_o = addr_q;
               stall_o    = 1'b1;
            end
            LOAD: begin
               load_ready_o = 1'b1;
               stall_o      = 1'b1;
               mem_en_o     = load_valid_i;
               mem_we_o     = load_valid_i;
               mem_addr_o   = addr_q;
               mem_wdata_o  = load_data_i;
            end
            RUN: begin
               stall_o   = fetch_req && !fetch_gnt;
               dbg_gnt_o = dbg_gnt;
               if (fetch_gnt) begin
                  mem_en_o   = 1'b1;
                  mem_addr_o = pc_addr_i[AW+1:2];
               end else if (dbg_gnt) begin
                  mem_en_o    = 1'b1;
                  mem_we_o    = dbg_we_i;
                  mem_addr_o  = dbg_addr_i;
                  mem_wdata_o = dbg_wdata_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign boot_done_o = (state_q == RUN);

   // read-return tracking and held output values
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pend_q  <= 1'b0;
         dbg_rd_pend_q <= 1'b0;
         err_pend_q    <= 1'b0;
         instr_q       <= NOP;
         dbg_rdata_q   <= '0;
      end else begin
         fetch_pend_q  <= fetch_gnt;
         dbg_rd_pend_q <= dbg_gnt && !dbg_we_i;
         err_pend_q    <= err_req;
         instr_q       <= instr_o;
         dbg_rdata_q   <= dbg_rdata_o;
      end
   end

   // read data arrives the cycle after the access, so it is steered straight out
   assign instr_o       = fetch_pend_q ? mem_rdata_i : (err_pend_q ? NOP : instr_q);
   assign instr_valid_o = fetch_pend_q || err_pend_q;
   assign addr_err_o    = err_pend_q;
   assign dbg_rdata_o   = dbg_rd_pend_q ? mem_rdata_i : dbg_rdata_q;
   assign dbg_rvalid_o  = dbg_rd_pend_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: behavioural SRAM, word-array reference model,
// directed boot/reset sequences plus randomized RUN traffic.
module tb_imem_ctrl;
   import imem_ctrl_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          fetch_req_i = 1'b0;
   logic [31:0]   pc_addr_i = '0;
   logic [31:0]   instr_o;
   logic          instr_valid_o, stall_o, addr_err_o, boot_done_o;
   logic          load_valid_i = 1'b0;
   logic          load_ready_o;
   logic [31:0]   load_data_i = '0;
   logic          load_last_i = 1'b0;
   logic          dbg_req_i = 1'b0, dbg_we_i = 1'b0;
   logic [AW-1:0] dbg_addr_i = '0;
   logic [31:0]   dbg_wdata_i = '0;
   logic          dbg_gnt_o;
   logic [31:0]   dbg_rdata_o;
   logic          dbg_rvalid_o;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i = '0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] sram    [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   int          denied;
   logic        exp_ivalid, exp_err, exp_drv;
   logic [31:0] exp_instr, exp_drd;

   imem_ctrl dut (
      .clk_i, .rst_i, .fetch_req_i, .pc_addr_i, .instr_o, .instr_valid_o,
      .stall_o, .addr_err_o, .boot_done_o, .load_valid_i, .load_ready_o,
      .load_data_i, .load_last_i, .dbg_req_i, .dbg_we_i, .dbg_addr_i,
      .dbg_wdata_i, .dbg_gnt_o, .dbg_rdata_o, .dbg_rvalid_o, .mem_en_o,
      .mem_we_o, .mem_addr_o, .mem_wdata_o, .mem_rdata_i
   );

   always #5 clk_i = ~clk_i;

   // single-port synchronous memory with one-cycle read latency
   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
         else          mem_rdata_i      <= sram[mem_addr_o];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_stall"},  32'(stall_o), 32'd0);
      chk({tag, "_men"},    32'(mem_en_o), 32'd0);
      chk({tag, "_mwe"},    32'(mem_we_o), 32'd0);
      chk({tag, "_maddr"},  32'(mem_addr_o), 32'd0);
      chk({tag, "_mwdata"}, mem_wdata_o, 32'd0);
      chk({tag, "_ready"},  32'(load_ready_o), 32'd0);
      chk({tag, "_boot"},   32'(boot_done_o), 32'd0);
      chk({tag, "_instr"},  instr_o, 32'd0);
      chk({tag, "_ivalid"}, 32'(instr_valid_o), 32'd0);
      chk({tag, "_aerr"},   32'(addr_err_o), 32'd0);
      chk({tag, "_dgnt"},   32'(dbg_gnt_o), 32'd0);
      chk({tag, "_drdata"}, dbg_rdata_o, 32'd0);
      chk({tag, "_drvalid"}, 32'(dbg_rvalid_o), 32'd0);
   endtask

   // entered on the negedge at which rst_i was released
   task automatic do_clear();
      denied     = 0;
      exp_ivalid = 1'b0;
      exp_err    = 1'b0;
      exp_drv    = 1'b0;
      exp_instr  = '0;
      exp_drd    = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         chk("clr_en",    32'(mem_en_o), 32'd1);
         chk("clr_we",    32'(mem_we_o), 32'd1);
         chk("clr_addr",  32'(mem_addr_o), 32'(i));
         chk("clr_wdata", mem_wdata_o, 32'd0);
         chk("clr_stall", 32'(stall_o), 32'd1);
         chk("clr_ready", 32'(load_ready_o), 32'd0);
         @(negedge clk_i);
      end
      #1;
      chk("load_ready", 32'(load_ready_o), 32'd1);
      chk("load_stall", 32'(stall_o), 32'd1);
      chk("load_boot",  32'(boot_done_o), 32'd0);
   endtask

   task automatic load_word(input logic [31:0] d, input logic last, input int k);
      load_valid_i = 1'b1;
      load_data_i  = d;
      load_last_i  = last;
      #1;
      chk("ld_ready", 32'(load_ready_o), 32'd1);
      chk("ld_en",    32'(mem_en_o), 32'd1);
      chk("ld_we",    32'(mem_we_o), 32'd1);
      chk("ld_addr",  32'(mem_addr_o), 32'(k));
      chk("ld_wdata", mem_wdata_o, d);
      chk("ld_stall", 32'(stall_o), 32'd1);
      chk("ld_boot",  32'(boot_done_o), 32'd0);
      chk("ld_dgnt",  32'(dbg_gnt_o), 32'd0);
      ref_mem[k] = d;
      @(negedge clk_i);
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
   endtask

   // one RUN cycle: check last cycle's returns, predict and check this cycle
   task automatic run_cycle(input logic fr, input logic [31:0] pc, input logic dr,
                            input logic dwe, input logic [AW-1:0] da, input logic [31:0] dwd);
      logic pc_ok, f_want, f_err, f_win, d_win;
      int   w;
      fetch_req_i = fr;
      pc_addr_i   = pc;
      dbg_req_i   = dr;
      dbg_we_i    = dwe;
      dbg_addr_i  = da;
      dbg_wdata_i = dwd;
      #1;
      chk("instr_valid", 32'(instr_valid_o), 32'(exp_ivalid));
      chk("instr",       instr_o, exp_instr);
      chk("addr_err",    32'(addr_err_o), 32'(exp_err));
      chk("dbg_rvalid",  32'(dbg_rvalid_o), 32'(exp_drv));
      if (exp_drv) chk("dbg_rdata", dbg_rdata_o, exp_drd);

      pc_ok  = (pc[1:0] == 2'b00) && (pc < 32'(DEPTH * 4));
      w      = int'(pc >> 2);
      f_want = fr && pc_ok;
      f_err  = fr && !pc_ok;
      f_win  = f_want && (denied < STARVE_MAX);
      d_win  = dr && !f_win;

      chk("run_boot",  32'(boot_done_o), 32'd1);
      chk("run_ready", 32'(load_ready_o), 32'd0);
      chk("stall",     32'(stall_o), 32'(f_want && !f_win));
      chk("dbg_gnt",   32'(dbg_gnt_o), 32'(d_win));
      chk("mem_en",    32'(mem_en_o), 32'(f_win || d_win));
      if (f_win) begin
         chk("f_addr", 32'(mem_addr_o), 32'(w));
         chk("f_we",   32'(mem_we_o), 32'd0);
      end
      if (d_win) begin
         chk("d_addr", 32'(mem_addr_o), 32'(da));
         chk("d_we",   32'(mem_we_o), 32'(dwe));
         if (dwe) chk("d_wdata", mem_wdata_o, dwd);
      end

      denied     = (dr && !d_win) ? denied + 1 : 0;
      exp_ivalid = f_win || f_err;
      exp_err    = f_err;
      if (f_win)      exp_instr = ref_mem[w];
      else if (f_err) exp_instr = 32'd0;
      exp_drv = d_win && !dwe;
      if (exp_drv) exp_drd = ref_mem[da];
      if (d_win && dwe) ref_mem[da] = dwd;
      @(negedge clk_i);
   endtask

   task automatic rand_cycle();
      logic [31:0] pc;
      int sel;
      sel = $urandom_range(0, 9);
      pc  = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      if (sel == 8)      pc = pc | 32'($urandom_range(1, 3));
      else if (sel == 9) pc = $urandom | 32'h0000_0080;
      run_cycle($urandom_range(0, 9) < 7, pc, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;
      #2 rst_i = 1'b0;
      @(negedge clk_i);
      #1;
      chk_reset_outputs("rst0");
      @(negedge clk_i);
      rst_i = 1'b1;
      do_clear();

      // short image, last word flagged
      load_word($urandom, 1'b0, 0);
      load_word($urandom, 1'b0, 1);
      load_word(32'h2008_0005, 1'b1, 2);
      run_cycle(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
      #1;
      chk("boot_fetch", instr_o, 32'h2008_0005);

      // invalid PCs: no memory access, NOP + error the next cycle
      run_cycle(1'b1, 32'h2,  1'b0, 1'b0, '0, '0);
      run_cycle(1'b1, 32'h80, 1'b0, 1'b0, '0, '0);
      #1;
      chk("err_80_flag", 32'(addr_err_o), 32'd1);
      chk("err_80_instr", instr_o, 32'd0);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);

      // starvation: debug write to the fetched word forces through on cycle 5
      for (int c = 0; c < 6; c++)
         run_cycle(1'b1, 32'h10, 1'b1, 1'b1, 5'd4, 32'hCAFE_0001);
      #1;
      chk("starve_reread", instr_o, 32'hCAFE_0001);
      for (int c = 0; c < 10; c++)
         run_cycle(1'b1, 32'h4, 1'b1, 1'b0, 5'd2, '0);

      for (int n = 0; n < 300; n++) rand_cycle();

      // reset from RUN, then reset again in the middle of a load
      fetch_req_i = 1'b0;
      dbg_req_i   = 1'b0;
      rst_i       = 1'b0;
      #1;
      chk_reset_outputs("rst_run");
      @(negedge clk_i);
      rst_i = 1'b1;
      do_clear();
      for (int k = 0; k < 5; k++) load_word($urandom, 1'b0, k);
      load_valid_i = 1'b1;
      load_data_i  = $urandom;
      rst_i        = 1'b0;
      #1;
      chk_reset_outputs("rst_load");
      @(negedge clk_i);
      load_valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      do_clear();

      // full image with no last flag; debug and fetch held up but denied
      fetch_req_i = 1'b1;
      dbg_req_i   = 1'b1;
      for (int k = 0; k < DEPTH; k++) load_word($urandom, 1'b0, k);
      fetch_req_i  = 1'b0;
      dbg_req_i    = 1'b0;
      load_valid_i = 1'b1;
      load_data_i  = 32'hDEAD_BEEF;
      #1;
      chk("full_boot",  32'(boot_done_o), 32'd1);
      chk("full_ready", 32'(load_ready_o), 32'd0);
      chk("extra_en",   32'(mem_en_o), 32'd0);
      @(negedge clk_i);
      load_valid_i = 1'b0;
      for (int n = 0; n < 32; n++)
         run_cycle(1'b1, 32'(n * 4), 1'b0, 1'b0, '0, '0);
      for (int n = 0; n < 150; n++) rand_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
